// File: rtl/mac_pkg.sv
// Shared MAC definitions: arbiter FSM state codes, the default frame-size
// limit and a few byte constants also used by the TX encapsulator.
package mac_pkg;

  // Largest frame forwarded without FCS: DA + SA + type + 1500 payload.
  localparam int MAX_FRAME_BYTES_DEF = 1514;

  // Byte constants used by the encapsulator when it frames the stream.
  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
  localparam logic [7:0] ETH_PAD_BYTE      = 8'h00;

  // Arbiter FSM state encoding, kept as plain constants for older tools.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_XFER    = 2'd1;
  localparam arb_state_t ST_DISCARD = 2'd2;

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Byte-wide AXI-Stream bundle between NUM_PORTS frame sources, the TX
// arbiter and the encapsulator. The slave modport is the arbiter side; the
// master modport is everything around it (sources plus downstream sink).
interface mac_tx_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS*8-1:0] s_tdata;
  logic [NUM_PORTS-1:0]   s_tvalid;
  logic [NUM_PORTS-1:0]   s_tready;
  logic [NUM_PORTS-1:0]   s_tlast;
  logic [NUM_PORTS-1:0]   s_tuser;
  logic [7:0]             m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic                   m_tuser;

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser,
    input  s_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tuser,
    output m_tready
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser,
    output s_tready,
    output m_tdata, m_tvalid, m_tlast, m_tuser,
    input  m_tready
  );
endinterface

// File: rtl/mac_tx_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: returns the first requester after
// the previous winner, wrapping around. Shared with the RX/queue arbiters.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan last+1, last+2, ... (mod NUM_PORTS) and keep the first request hit.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_PORTS);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter in front of the MAC TX encapsulator.
// One source owns the output from grant until its tlast; runaway frames are
// cut at MAX_FRAME_BYTES (last beat flagged as error) and the rest dropped.
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_tx_arbiter_if.slave      bus,
  input  logic [NUM_PORTS-1:0] port_enable,
  input  logic                 pause,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 busy,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FRAME_BYTES - 1);

  arb_state_t           state_reg;
  logic [NUM_PORTS-1:0] grant_reg;
  logic [IDX_W-1:0]     sel_reg;      // also serves as last_winner
  logic [CNT_W-1:0]     count_reg;
  logic                 overflow_reg;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_idx;

  logic [7:0] port_data [NUM_PORTS];
  logic [7:0] sel_tdata;
  logic       sel_tvalid;
  logic       sel_tlast;
  logic       sel_tuser;
  logic       at_limit;
  logic       beat;

  // Split the flat data bus into one byte lane per source.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
    assign port_data[gi] = bus.s_tdata[8*gi +: 8];
  end

  assign req        = bus.s_tvalid & port_enable;
  assign sel_tdata  = port_data[sel_reg];
  assign sel_tvalid = bus.s_tvalid[sel_reg];
  assign sel_tlast  = bus.s_tlast[sel_reg];
  assign sel_tuser  = bus.s_tuser[sel_reg];
  // The beat at byte index MAX_FRAME_BYTES-1 is the last one we may forward.
  assign at_limit   = (count_reg == LAST_IDX);
  assign beat       = (state_reg == ST_XFER) && sel_tvalid && bus.m_tready;

  assign grant    = grant_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign overflow = overflow_reg;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req  (req),
    .last (sel_reg),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // Output mux: zero-latency passthrough of the owner in XFER, sink-all in DISCARD.
  always_comb begin
    bus.m_tdata  = 8'h00;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tuser  = 1'b0;
    bus.s_tready = '0;
    case (state_reg)
      ST_XFER: begin
        bus.m_tdata  = sel_tdata;
        bus.m_tvalid = sel_tvalid;
        bus.m_tlast  = sel_tlast | at_limit;
        bus.m_tuser  = sel_tuser | (at_limit & ~sel_tlast);
        bus.s_tready = grant_reg & {NUM_PORTS{bus.m_tready}};
      end
      ST_DISCARD: begin
        bus.s_tready = grant_reg;
      end
      default: ;
    endcase
  end

  // Frame FSM: grant between frames, count beats, truncate runaway frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      sel_reg      <= IDX_W'(NUM_PORTS - 1);
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!pause && (req != '0)) begin
            state_reg <= ST_XFER;
            grant_reg <= arb_gnt;
            sel_reg   <= arb_idx;
            count_reg <= '0;
          end
        end
        ST_XFER: begin
          if (beat) begin
            if (sel_tlast) begin
              state_reg <= ST_IDLE;
              grant_reg <= '0;
            end else if (at_limit) begin
              state_reg    <= ST_DISCARD;
              overflow_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
            end
          end
        end
        ST_DISCARD: begin
          if (sel_tvalid && sel_tlast) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: per-port source queues drive the inputs, a
// frame-level round-robin model predicts the output byte stream and grant
// sequence, and a monitor pops the scoreboard on every output beat.
module tb_mac_tx_arbiter;

  localparam int NP   = 4;
  localparam int MAXB = 1514;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       first;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] port_enable;
  logic          pause;
  logic [NP-1:0] grant;
  logic          busy;
  logic          overflow;

  mac_tx_arbiter_if #(.NUM_PORTS(NP)) bus ();

  mac_tx_arbiter #(
    .NUM_PORTS       (NP),
    .MAX_FRAME_BYTES (MAXB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .port_enable (port_enable),
    .pause       (pause),
    .grant       (grant),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  beat_t         src_q [NP][$];
  beat_t         mdl_q [NP][$];
  beat_t         exp_q [$];
  logic [NP-1:0] gexp_q [$];
  logic [NP-1:0] gobs_q [$];
  int            model_last = NP - 1;
  int            ovf_exp    = 0;
  int            ovf_seen   = 0;
  int            ready_mode = 2;   // 0 random, 1 toggle, 2 always, 3 never
  bit            rand_pause = 1'b0;
  logic          pause_cmd  = 1'b0;
  bit            mon_en     = 1'b0;
  logic [NP-1:0] prev_grant = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Queue one frame on a source; the model keeps its own copy.
  function automatic void add_frame(int p, int len, bit err);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = 8'($urandom);
      b.last  = (k == len - 1);
      b.user  = err && (k == len - 1);
      b.first = (k == 0);
      src_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
  endfunction

  // Reference: serve whole frames round-robin among ports with pending frames,
  // cutting any frame at MAXB bytes; predicts bytes, grants and overflow count.
  function automatic void model_run();
    int            w;
    int            c;
    int            k;
    bit            found;
    bit            trunc;
    beat_t         b;
    beat_t         e;
    logic [NP-1:0] oh;
    forever begin
      found = 1'b0;
      w = 0;
      for (int off = 1; off <= NP; off++) begin
        c = (model_last + off) % NP;
        if (!found && mdl_q[c].size() > 0) begin
          w = c;
          found = 1'b1;
        end
      end
      if (!found) break;
      model_last = w;
      oh = '0;
      oh[w] = 1'b1;
      gexp_q.push_back(oh);
      k = 0;
      trunc = 1'b0;
      while (mdl_q[w].size() > 0) begin
        b = mdl_q[w].pop_front();
        if (!trunc) begin
          e = b;
          e.first = 1'b0;
          if (k == MAXB - 1 && !b.last) begin
            e.last = 1'b1;
            e.user = 1'b1;
            trunc = 1'b1;
            ovf_exp++;
          end
          exp_q.push_back(e);
          k++;
        end
        if (b.last) break;
      end
      gexp_q.push_back('0);
    end
  endfunction

  function automatic bit sources_empty();
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // Source/sink driver: consume on handshake, present next byte after each edge.
  initial begin
    logic [NP-1:0]   fire;
    logic [NP*8-1:0] td;
    logic [NP-1:0]   tv, tl, tu;
    beat_t           b;
    bus.s_tdata  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tuser  = '0;
    bus.m_tready = 1'b0;
    pause        = 1'b0;
    forever begin
      @(negedge clk);
      fire = bus.s_tvalid & bus.s_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
        if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0) begin
          b = src_q[p][0];
          tv[p] = b.first || ($urandom_range(0, 3) != 0);
          td[8*p +: 8] = b.data;
          tl[p] = b.last;
          tu[p] = b.user;
        end else begin
          tv[p] = 1'b0;
          td[8*p +: 8] = 8'($urandom);
          tl[p] = 1'($urandom);
          tu[p] = 1'($urandom);
        end
      end
      bus.s_tdata  = td;
      bus.s_tvalid = tv;
      bus.s_tlast  = tl;
      bus.s_tuser  = tu;
      case (ready_mode)
        0:       bus.m_tready = ($urandom_range(0, 3) != 0);
        1:       bus.m_tready = ~bus.m_tready;
        2:       bus.m_tready = 1'b1;
        default: bus.m_tready = 1'b0;
      endcase
      pause = rand_pause ? ($urandom_range(0, 7) == 0) : pause_cmd;
    end
  end

  // Monitor: scoreboard pop per output beat plus ready/grant observations.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.m_tvalid && bus.m_tready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_beat: got data %0h with nothing expected", bus.m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data_last_user", {22'd0, bus.m_tdata, bus.m_tlast, bus.m_tuser},
                  {22'd0, e.data, e.last, e.user});
          end
        end
        if (bus.m_tvalid) begin
          check("s_tready_mirror", 32'(bus.s_tready), 32'(bus.m_tready ? grant : '0));
          check("valid_has_owner", 32'(busy && grant != '0), 32'd1);
        end else if (!busy) begin
          check("idle_no_ready", 32'(bus.s_tready), 32'd0);
        end
        if (grant != prev_grant) gobs_q.push_back(grant);
        if (grant != '0 && prev_grant == '0)
          check("first_byte_with_grant", {30'd0, busy, bus.m_tvalid}, 32'd3);
        if (overflow) ovf_seen++;
        prev_grant = grant;
      end
    end
  end

  task automatic finish_phase(string name, int budget);
    int n;
    bit ok;
    int bad;
    n = 0;
    while (n < budget && (!sources_empty() || exp_q.size() > 0 || busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got %0d beats still expected after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
    repeat (2) @(negedge clk);
    compared++;
    ok = (gobs_q.size() == gexp_q.size());
    bad = -1;
    for (int i = 0; i < gobs_q.size() && i < gexp_q.size(); i++)
      if (bad < 0 && gobs_q[i] !== gexp_q[i]) bad = i;
    if (bad >= 0) ok = 1'b0;
    if (!ok) begin
      mismatched++;
      if (bad >= 0)
        $display("FAIL %s_grant_seq: got %b expected %b at change %0d", name,
                 gobs_q[bad], gexp_q[bad], bad);
      else
        $display("FAIL %s_grant_seq: got %0d grant changes expected %0d", name,
                 gobs_q.size(), gexp_q.size());
    end
    check({name, "_overflow_pulses"}, 32'(ovf_seen), 32'(ovf_exp));
    exp_q.delete();
    gobs_q.delete();
    gexp_q.delete();
    ovf_seen = 0;
    ovf_exp  = 0;
  endtask

  task automatic wait_grant(logic [NP-1:0] want, int budget, string name);
    int n;
    n = 0;
    while (n < budget && grant !== want) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(grant), 32'(want));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish within time limit, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    port_enable = '1;
    ready_mode  = 2;
    repeat (2) @(negedge clk);
    // Two-port frames loaded while reset holds; port 0 must win first.
    add_frame(0, 60, 1'b0);
    add_frame(2, 60, 1'b0);
    model_run();
    repeat (2) @(negedge clk);
    check("reset_s_tready", 32'(bus.s_tready), 32'd0);
    check("reset_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("reset_m_tlast",  32'(bus.m_tlast), 32'd0);
    check("reset_m_tuser",  32'(bus.m_tuser), 32'd0);
    check("reset_m_tdata",  32'(bus.m_tdata), 32'd0);
    check("reset_grant",    32'(grant), 32'd0);
    check("reset_busy",     32'(busy), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    finish_phase("two_port", 2000);

    // Every port backlogged with four 64-byte frames.
    ready_mode = 0;
    rand_pause = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < NP; p++) add_frame(p, 64, 1'b0);
    model_run();
    finish_phase("rotate16", 6000);

    // Sink toggles ready every cycle under a 100-byte frame.
    ready_mode = 1;
    rand_pause = 1'b0;
    @(negedge clk);
    add_frame(1, 100, 1'b1);
    model_run();
    finish_phase("ready_toggle", 1000);

    // Size limit: runaway frame, exact-limit frame, one byte over.
    ready_mode = 0;
    @(negedge clk);
    add_frame(1, 1600, 1'b0);
    add_frame(3, MAXB, 1'b0);
    add_frame(0, MAXB + 1, 1'b0);
    model_run();
    finish_phase("truncate", 20000);

    // Pause and port_enable dropped mid-frame do not abort the frame.
    @(negedge clk);
    add_frame(3, 40, 1'b0);
    model_run();
    wait_grant(4'b1000, 50, "pause_first_grant");
    pause_cmd = 1'b1;
    port_enable[3] = 1'b0;
    add_frame(0, 30, 1'b0);
    model_run();
    for (int n = 0; n < 1000 && busy; n++) @(negedge clk);
    check("pause_frame_done", 32'(busy), 32'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("pause_hold_grant", 32'(grant), 32'd0);
    end
    port_enable[3] = 1'b1;
    pause_cmd = 1'b0;
    @(negedge clk);
    check("pause_release_same_cycle", 32'(grant), 32'd0);
    @(negedge clk);
    check("pause_release_grant", 32'(grant), 32'd1);
    finish_phase("pause", 1000);

    // Randomized mixes of frame counts, lengths and error flags.
    ready_mode = 0;
    rand_pause = 1'b1;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        int nf;
        nf = (p == r % NP) ? $urandom_range(1, 3) : $urandom_range(0, 3);
        for (int f = 0; f < nf; f++)
          add_frame(p, $urandom_range(1, 100), ($urandom_range(0, 9) == 0));
      end
      model_run();
      finish_phase("random", 6000);
    end

    // Reset in the middle of a frame.
    rand_pause = 1'b0;
    ready_mode = 2;
    @(negedge clk);
    add_frame(1, 200, 1'b0);
    model_run();
    wait_grant(4'b0010, 50, "midreset_grant");
    repeat (20) @(negedge clk);
    ready_mode = 3;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("midreset_grant_cleared", 32'(grant), 32'd0);
    check("midreset_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("midreset_s_tready", 32'(bus.s_tready), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
    end
    exp_q.delete();
    gobs_q.delete();
    gexp_q.delete();
    ovf_seen   = 0;
    ovf_exp    = 0;
    model_last = NP - 1;
    @(negedge clk);
    reset      = 1'b0;
    prev_grant = '0;
    mon_en     = 1'b1;
    ready_mode = 0;
    add_frame(0, 30, 1'b0);
    add_frame(2, 30, 1'b0);
    model_run();
    finish_phase("after_reset", 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
